// File: rtl/mycpu_pkg.sv
// mycpu_pkg: trace record widths, record layout and capture filter shared by the trace buffer
package mycpu_pkg;
  localparam int TRACE_PC_W    = 32;
  localparam int TRACE_WNUM_W  = 5;
  localparam int TRACE_WDATA_W = 32;
  localparam int TRACE_REC_W   = TRACE_PC_W + TRACE_WNUM_W + TRACE_WDATA_W;
  typedef struct packed {
    logic [TRACE_PC_W-1:0]    pc;
    logic [TRACE_WNUM_W-1:0]  wnum;
    logic [TRACE_WDATA_W-1:0] wdata;
  } trace_rec_t;
  function automatic logic capture_hit(input logic [3:0] we, input logic [TRACE_WNUM_W-1:0] wnum,
                                       input logic all);
    return (we != 4'd0) && (all || wnum != '0);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a push while full is taken only if a pop frees the slot
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic do_push, do_pop;
  always_comb begin
    empty    = level_q == '0;
    full     = level_q == (AW+1)'(DEPTH);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout     = mem_q[rd_ptr_q];
    level    = level_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: filters CPU writeback trace into a FWFT FIFO with sticky overflow and drop count
module wb_trace_buffer
  import mycpu_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CAPTURE_ALL = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               debug_wb_pc,
  input  logic [3:0]                debug_wb_rf_we,
  input  logic [4:0]                debug_wb_rf_wnum,
  input  logic [31:0]               debug_wb_rf_wdata,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [31:0]               trace_pc,
  output logic [4:0]                trace_wnum,
  output logic [31:0]               trace_wdata,
  input  logic                      ovf_clr,
  output logic                      overflow,
  output logic [15:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]    level
);
  trace_rec_t rec_in, rec_out;
  logic capture, pop_fire, drop, full, empty;
  logic overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  sync_fifo #(.WIDTH(TRACE_REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(capture), .din(rec_in), .pop(pop_fire),
    .dout(rec_out), .full(full), .empty(empty), .level(level)
  );
  always_comb begin
    rec_in      = '{pc: debug_wb_pc, wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata};
    capture     = capture_hit(debug_wb_rf_we, debug_wb_rf_wnum, CAPTURE_ALL != 0);
    trace_valid = !empty;
    pop_fire    = trace_valid && trace_ready;
    drop        = capture && full && !pop_fire;
    // a drop on the clearing edge restarts the count at one
    overflow_d  = drop ? 1'b1 : ovf_clr ? 1'b0 : overflow_q;
    drop_cnt_d  = drop ? (ovf_clr ? 16'd1 : drop_cnt_q == 16'hFFFF ? drop_cnt_q : drop_cnt_q + 16'd1)
                : ovf_clr ? 16'd0 : drop_cnt_q;
    trace_pc    = rec_out.pc;
    trace_wnum  = rec_out.wnum;
    trace_wdata = rec_out.wdata;
    overflow    = overflow_q;
    drop_cnt    = drop_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed and random stimulus against a queue-based model of two buffer variants
module tb_wb_trace_buffer;
  logic clk = 0, rst = 1;
  logic [31:0] pc = 0, wdata = 0;
  logic [3:0] we = 0;
  logic [4:0] wnum = 0;
  logic ready = 0, clr = 0;
  logic valid [2];
  logic [31:0] t_pc [2], t_wdata [2];
  logic [4:0] t_wnum [2];
  logic ovf [2];
  logic [15:0] dcnt [2];
  logic [4:0] lvl [2];
  int n_cmp = 0, n_bad = 0;
  logic [68:0] q0[$], q1[$], tq[$];
  logic m_ovf [2];
  logic [15:0] m_dc [2];
  bit chk_en = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(16), .CAPTURE_ALL(0)) dut (
    .clk(clk), .rst(rst), .debug_wb_pc(pc), .debug_wb_rf_we(we), .debug_wb_rf_wnum(wnum),
    .debug_wb_rf_wdata(wdata), .trace_valid(valid[0]), .trace_ready(ready), .trace_pc(t_pc[0]),
    .trace_wnum(t_wnum[0]), .trace_wdata(t_wdata[0]), .ovf_clr(clr), .overflow(ovf[0]),
    .drop_cnt(dcnt[0]), .level(lvl[0]));
  wb_trace_buffer #(.DEPTH(16), .CAPTURE_ALL(1)) dut_all (
    .clk(clk), .rst(rst), .debug_wb_pc(pc), .debug_wb_rf_we(we), .debug_wb_rf_wnum(wnum),
    .debug_wb_rf_wdata(wdata), .trace_valid(valid[1]), .trace_ready(ready), .trace_pc(t_pc[1]),
    .trace_wnum(t_wnum[1]), .trace_wdata(t_wdata[1]), .ovf_clr(clr), .overflow(ovf[1]),
    .drop_cnt(dcnt[1]), .level(lvl[1]));

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit cap, pop, full, drop;
      tq = (i == 0) ? q0 : q1;
      if (rst) begin
        tq.delete();
        m_ovf[i] = 0;
        m_dc[i] = 0;
      end else begin
        cap = we != 0 && (i == 1 || wnum != 0);
        pop = tq.size() > 0 && ready;
        full = tq.size() == 16;
        drop = cap && full && !pop;
        if (pop) void'(tq.pop_front());
        if (cap && !drop) tq.push_back({pc, wnum, wdata});
        if (drop) begin
          m_ovf[i] = 1;
          m_dc[i] = clr ? 16'd1 : (m_dc[i] == 16'hFFFF ? m_dc[i] : m_dc[i] + 16'd1);
        end else if (clr) begin
          m_ovf[i] = 0;
          m_dc[i] = 0;
        end
      end
      if (i == 0) q0 = tq; else q1 = tq;
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        tq = (i == 0) ? q0 : q1;
        check($sformatf("valid%0d", i), 69'(valid[i]), 69'(tq.size() > 0));
        check($sformatf("level%0d", i), 69'(lvl[i]), 69'(tq.size()));
        check($sformatf("overflow%0d", i), 69'(ovf[i]), 69'(m_ovf[i]));
        check($sformatf("drop_cnt%0d", i), 69'(dcnt[i]), 69'(m_dc[i]));
        if (tq.size() > 0) check($sformatf("head%0d", i), {t_pc[i], t_wnum[i], t_wdata[i]}, tq[0]);
      end
    end
  end

  task automatic step(input logic [31:0] p, input logic [3:0] w, input logic [4:0] n,
                      input logic [31:0] d, input logic r, input logic c, input logic rs);
    @(negedge clk);
    pc = p; we = w; wnum = n; wdata = d; ready = r; clr = c; rst = rs;
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rst_level", 69'(lvl[0]), 69'(0));
    check("rst_valid", 69'(valid[0]), 69'(0));
    step(32'h1c000000, 4'hF, 5'd3, 32'h12345678, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("cap_valid", 69'(valid[0]), 69'(1));
    check("cap_rec", {t_pc[0], t_wnum[0], t_wdata[0]}, {32'h1c000000, 5'd3, 32'h12345678});
    step(0, 0, 0, 0, 1, 0, 0);
    check("pop_level", 69'(lvl[0]), 69'(0));
    step(32'h20, 4'hF, 5'd0, 32'hAA, 0, 0, 0);
    step(32'h24, 4'h0, 5'd5, 32'hBB, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("r0_filtered", 69'(valid[0]), 69'(0));
    check("r0_capture_all", 69'(lvl[1]), 69'(1));
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 18; i++) step(32'h100 + 4 * i, 4'hF, 5'd1 + 5'(i), 32'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("full_level", 69'(lvl[0]), 69'(16));
    check("full_ovf", 69'(ovf[0]), 69'(1));
    check("full_drops", 69'(dcnt[0]), 69'(2));
    check("full_head", 69'(t_pc[0]), 69'(32'h100));
    step(32'h999, 4'hF, 5'd7, 32'h77, 1, 0, 0);
    step(32'h998, 4'hF, 5'd7, 32'h66, 0, 1, 0);
    check("popcap_level", 69'(lvl[0]), 69'(16));
    check("popcap_drops", 69'(dcnt[0]), 69'(2));
    step(0, 0, 0, 0, 0, 1, 0);
    check("clr_drop_ovf", 69'(ovf[0]), 69'(1));
    check("clr_drop_cnt", 69'(dcnt[0]), 69'(1));
    step(0, 0, 0, 0, 1, 0, 0);
    check("clr_ovf", 69'(ovf[0]), 69'(0));
    check("clr_cnt", 69'(dcnt[0]), 69'(0));
    for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(32'h300 + 4 * i, 4'h3, 5'd9, 32'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("pre_rst_level", 69'(lvl[0]), 69'(5));
    step(32'h400, 4'hF, 5'd9, 32'h1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rst_mid_level", 69'(lvl[0]), 69'(0));
    check("rst_mid_valid", 69'(valid[0]), 69'(0));
    for (int i = 0; i < 3000; i++) begin
      int bias = (i / 300) % 3;
      step($urandom, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
           ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
           $urandom_range(0, 3) < bias + 1, $urandom_range(0, 49) == 0, $urandom_range(0, 499) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter CAPTURE_ALL, default 0; 1 = capture every we!=0 write including r0.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports debug_wb_pc  input  32, debug_wb_rf_we  input  4, debug_wb_rf_wnum  input  5, debug_wb_rf_wdata  input  32; the writeback trace from the CPU top.
REQ-006 SHALL have ports trace_valid  output  1, trace_ready  input  1; the downstream stream handshake.
REQ-007 SHALL have ports trace_pc  output  32, trace_wnum  output  5, trace_wdata  output  32; the head record.
REQ-008 SHALL have port ovf_clr  input  1; clears the overflow flag and the drop counter.
REQ-009 SHALL have ports overflow  output  1 (sticky) and drop_cnt  output  16 (dropped records).
REQ-010 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-011 Capture condition SHALL be (debug_wb_rf_we != 0) AND (CAPTURE_ALL OR debug_wb_rf_wnum != 0), sampled at the rising edge.
REQ-012 A captured record SHALL be {pc, wnum, wdata} (69 bits), written at the tail on the capture edge.
REQ-013 FIFO SHALL be first-word-fall-through: a record captured into an empty FIFO at edge N SHALL drive trace_valid=1 with its fields in the cycle after edge N (1-cycle latency).
REQ-014 trace_valid SHALL equal (level != 0); trace_* fields SHALL be stable while trace_valid=1 and trace_ready=0.
REQ-015 Pop SHALL occur on an edge where trace_valid AND trace_ready.
REQ-016 Full with pop on the same edge: the capture SHALL be accepted, level unchanged, no drop.
REQ-017 Full without pop: the capture SHALL be dropped, overflow set to 1, drop_cnt incremented, saturating at 0xFFFF.
REQ-018 Empty with capture: no pop SHALL occur on that edge; no bypass of trace_* in the capture cycle.
REQ-019 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; level SHALL reach DEPTH when full.
REQ-020 ovf_clr SHALL clear overflow and drop_cnt on the next edge; a drop on that same edge SHALL win (overflow=1, drop_cnt=1).
REQ-021 Non-captured trace cycles SHALL leave all state unchanged except pop.

Reset
REQ-022 On rst=1 at an edge: pointers=0, level=0, trace_valid=0, overflow=0, drop_cnt=0; FIFO storage need not be cleared.
REQ-023 rst SHALL override capture, pop and ovf_clr on the same edge; records held before a mid-operation reset are discarded.
REQ-024 trace_pc/trace_wnum/trace_wdata SHALL be don't-care while trace_valid=0.

Structure
REQ-025 Shared package mycpu_pkg SHALL hold TRACE_PC_W=32, TRACE_WNUM_W=5, TRACE_WDATA_W=32 and TRACE_REC_W=69.
REQ-026 Storage and pointer logic SHALL be one sub-module sync_fifo (parameters WIDTH, DEPTH; FWFT; push/pop/full/empty/level); capture filter, overflow flag and drop counter stay in wb_trace_buffer.

Verification
REQ-027 Capture pc=0x1c000000, we=0xF, wnum=3, wdata=0x12345678 with ready=1: trace_valid=1 the next cycle with the same fields; popped; level returns to 0.
REQ-028 Apply we=0xF with wnum=0, then we=0 with wnum=5 (CAPTURE_ALL=0): no record; trace_valid stays 0. With CAPTURE_ALL=1 the wnum=0 write is captured.
REQ-029 ready=0, 18 consecutive captures with DEPTH=16: level=16, overflow=1, drop_cnt=2; the 16 records drain in order with the first 16 pc values.
REQ-030 Full FIFO, ready=1 with a capture on the same edge: level stays 16, drop_cnt unchanged, and the new record arrives last.
REQ-031 Assert ovf_clr on the same edge as a drop: overflow=1, drop_cnt=1. Assert ovf_clr alone next: both read 0.
REQ-032 With 5 entries held, assert rst for one edge with a concurrent capture: level=0, trace_valid=0, overflow=0 the next cycle; the capture is lost.
